// File: rtl/addsubz_serial.sv
// addsubz_serial: bit-serial add/subtract with zero flag, computed LSB first.
// Define ADDSUBZ_OVERFLOW_EN to add the registered signed-overflow output.
module addsubz_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             do_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             result_is_zero,
    output logic             busy
`ifdef ADDSUBZ_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic carry_q;
    logic carry_d;
    logic zacc_q;
    logic zacc_d;
    logic zero_q;
    logic zero_d;
    logic in_ready_q;
    logic in_ready_d;
    logic out_valid_q;
    logic out_valid_d;
    logic busy_q;
    logic busy_d;

    logic sum_bit;
    logic carry_out;
    logic last_bit;

    // The A register doubles as the result register: sum bits enter at
    // the MSB as operand bits leave at the LSB.
    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
        carry_out = (a_q[0] & b_q[0])
                  | (a_q[0] & carry_q)
                  | (b_q[0] & carry_q);
        last_bit  = (cnt_q == CW'(WIDTH - 1));

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        dout_d      = dout_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        zacc_d      = zacc_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = do_sub ? ~b : b;
                    carry_d    = do_sub;
                    cnt_d      = '0;
                    zacc_d     = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                a_d     = {sum_bit, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = carry_out;
                zacc_d  = zacc_q | sum_bit;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    dout_d      = {sum_bit, a_q[WIDTH-1:1]};
                    zero_d      = ~(zacc_q | sum_bit);
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign dout           = dout_q;
    assign result_is_zero = zero_q;
    assign busy           = busy_q;

`ifdef ADDSUBZ_OVERFLOW_EN
    logic ovf_q;
    logic ovf_d;

    // On the MSB step carry_q is the carry into the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == BUSY && last_bit) begin
            ovf_d = carry_q ^ carry_out;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule
